// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_addsub
//  Brief    : Digit-serial adder/subtractor. Operands are captured on start and
//             consumed DIGIT bits per clock through a DIGIT-bit adder with a
//             registered carry. Completion is flagged by a one-cycle done pulse
//             with carry-out and signed-overflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] contents_a,
  output logic [WIDTH-1:0] contents_b
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] c_last = CW'(N - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_dig;
  logic             w_cin_msb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sum_next;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == c_last);

  // One digit of the addition: low DIGIT bits of each operand plus the carry.
  assign w_dig = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, r_carry};

  // The carry into the digit's top bit is recovered from that bit's sum:
  // s = a ^ b ^ cin, so cin = a ^ b ^ s. Overflow is cin(MSB) ^ cout(MSB).
  assign w_cin_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dig[DIGIT-1];
  assign w_ovf     = w_cin_msb ^ w_dig[DIGIT];

  // New digit enters at the MSB end so the result ends up LSB-aligned.
  generate
    if (DIGIT == WIDTH) begin : g_sum_full
      assign w_sum_next = w_dig[DIGIT-1:0];
    end else begin : g_sum_shift
      assign w_sum_next = {w_dig[DIGIT-1:0], r_sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> IDLE after the last digit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on start, then shift one digit per cycle while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= mode ? ~b : b;
        r_carry <= mode;
        r_cnt   <= '0;
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_sum   <= w_sum_next;
        r_carry <= w_dig[DIGIT];
        if (w_last) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
          r_cout <= w_dig[DIGIT];
          r_ovf  <= w_ovf;
        end else begin
          r_cnt  <= r_cnt + c_one;
        end
      end
    end
  end

  assign busy       = (r_state == S_RUN);
  assign done       = r_done;
  assign sum        = r_sum;
  assign carry_out  = r_cout;
  assign overflow   = r_ovf;
  assign contents_a = r_a;
  assign contents_b = r_b;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_addsub
//  Brief    : Directed self-checking bench for serial_addsub (16/1, 16/4, 32/8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // 16-bit, 1 bit per step
  logic        start16 = 1'b0, mode16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16, ca16, cb16;

  // 16-bit, 4 bits per step
  logic        start4 = 1'b0, mode4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, cout4, ovf4;
  logic [15:0] sum4, ca4, cb4;

  // 32-bit, 8 bits per step
  logic        start8 = 1'b0, mode8 = 1'b0;
  logic [31:0] a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [31:0] sum8, ca8, cb8;

  serial_addsub #(.WIDTH(16), .DIGIT(1)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .mode(mode16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16),
    .carry_out(cout16), .overflow(ovf16), .contents_a(ca16), .contents_b(cb16));

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .mode(mode4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4),
    .carry_out(cout4), .overflow(ovf4), .contents_a(ca4), .contents_b(cb4));

  serial_addsub #(.WIDTH(32), .DIGIT(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .mode(mode8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
    .carry_out(cout8), .overflow(ovf8), .contents_a(ca8), .contents_b(cb8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation on the 16/1 instance. Returns in the done cycle so a
  // following call lands its start on the done edge (back-to-back case).
  // inject > 0 pulses start with junk operands at that step while busy.
  task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                      input logic tm, input logic [15:0] esum, input logic ecout,
                      input logic eovf, input int inject);
    int lat  = 0;
    int bcnt = 0;
    bit ovl  = 0;
    bit seen = 0;
    logic [15:0] exp_b;
    exp_b   = tm ? ~tb : tb;
    a16     = ta;
    b16     = tb;
    mode16  = tm;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk({tag, ".cap_a"}, ca16, ta);
    chk({tag, ".cap_b"}, cb16, exp_b);
    chk({tag, ".cap_sum"}, sum16, 16'h0000);
    if (busy16) bcnt++;
    for (int i = 1; i <= 40; i++) begin
      if (i == inject) begin
        start16 = 1'b1;
        a16     = 16'hFFFF;
        b16     = 16'hFFFF;
        mode16  = ~tm;
      end else begin
        start16 = 1'b0;
      end
      tick();
      lat = i;
      if (i == 1) chk({tag, ".shift_a"}, ca16, ta >> 1);
      if (busy16 && done16) ovl = 1'b1;
      if (done16) begin
        seen = 1'b1;
        break;
      end
      if (busy16) bcnt++;
    end
    start16 = 1'b0;
    chk({tag, ".done_seen"}, seen, 1'b1);
    chk({tag, ".latency"}, lat, 16);
    chk({tag, ".busy_cycles"}, bcnt, 16);
    chk({tag, ".busy_done_overlap"}, ovl, 1'b0);
    chk({tag, ".sum"}, sum16, esum);
    chk({tag, ".carry_out"}, cout16, ecout);
    chk({tag, ".overflow"}, ovf16, eovf);
    chk({tag, ".a_empty"}, ca16, 16'h0000);
    chk({tag, ".b_empty"}, cb16, 16'h0000);
  endtask

  initial begin
    int  lat;
    bit  seen;

    // Post-reset defaults with the clock running.
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst.busy", busy16, 1'b0);
    chk("rst.done", done16, 1'b0);
    chk("rst.sum", sum16, 16'h0000);
    chk("rst.carry_out", cout16, 1'b0);
    chk("rst.overflow", ovf16, 1'b0);
    chk("rst.contents_a", ca16, 16'h0000);
    chk("rst.contents_b", cb16, 16'h0000);
    reset_n = 1'b1;

    // Add with overflow.
    op16("add_ovf", 16'h83A9, 16'h83A9, 1'b0, 16'h0752, 1'b1, 1'b1, 0);
    tick();
    chk("add_ovf.done_pulse_width", done16, 1'b0);
    chk("add_ovf.sum_hold", sum16, 16'h0752);

    // Subtract with borrow, then signed overflow on subtraction.
    op16("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    tick();
    op16("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    tick();

    // Start pulses while busy are ignored; then back-to-back start on done.
    op16("ignore", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 5);
    op16("b2b", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 0);
    tick();

    // Reset in the middle of an operation.
    a16 = 16'h83A9; b16 = 16'h83A9; mode16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (7) tick();
    chk("midrst.busy_before", busy16, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.busy", busy16, 1'b0);
    chk("midrst.done", done16, 1'b0);
    chk("midrst.sum", sum16, 16'h0000);
    chk("midrst.contents_a", ca16, 16'h0000);
    chk("midrst.contents_b", cb16, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done16) seen = 1'b1;
    end
    chk("midrst.no_done", seen, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("midrst.idle_after", busy16, 1'b0);
    op16("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
    tick();

    // 16-bit, 4 bits per step.
    a4 = 16'hFFFF; b4 = 16'h0001; mode4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      lat = i;
      if (done4) begin
        seen = 1'b1;
        break;
      end
    end
    chk("d4.done_seen", seen, 1'b1);
    chk("d4.latency", lat, 4);
    chk("d4.sum", sum4, 16'h0000);
    chk("d4.carry_out", cout4, 1'b1);
    chk("d4.overflow", ovf4, 1'b0);

    // 32-bit, 8 bits per step.
    a8 = 32'h7FFFFFFF; b8 = 32'h00000001; mode8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      lat = i;
      if (done8) begin
        seen = 1'b1;
        break;
      end
    end
    chk("d8.done_seen", seen, 1'b1);
    chk("d8.latency", lat, 4);
    chk("d8.sum", sum8, 32'h80000000);
    chk("d8.carry_out", cout8, 1'b0);
    chk("d8.overflow", ovf8, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_addsub.md
# serial_addsub

Parametrised digit-serial adder/subtractor, the successor to the 16-bit bit-serial `shift_adder`. Two operands are captured on a start handshake and processed DIGIT bits per clock through a DIGIT-bit adder with a registered carry. The result is shifted into a result register, and completion is reported with a one-cycle `done` pulse plus carry and signed-overflow flags. It is used wherever a full-width parallel adder is too large and a latency of WIDTH/DIGIT cycles is acceptable.

## Interface
- WIDTH, 16: operand/result width in bits; ≥ 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH. Steps per operation: N = WIDTH/DIGIT.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when idle.
- mode  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- sum  output  WIDTH  result register.
- carry_out  output  1  final carry out of the MSB.
- overflow  output  1  two's-complement overflow of the final result.
- contents_a  output  WIDTH  live A shift register, for debug.
- contents_b  output  WIDTH  live B shift register (post-inversion), for debug.

## Operation
- FSM has two states.
  - IDLE: busy=0. If start=1 at a clock edge:
    - a_reg ← a.
    - b_reg ← mode ? ~b : b.
    - carry ← mode.
    - step counter ← 0.
    - sum ← 0.
    - Transition to RUN.
  - RUN: busy=1. Each edge:
    - {c, d} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry.
    - a_reg and b_reg shift right by DIGIT, zero fill.
    - sum ← {d, sum[WIDTH-1:DIGIT]}; the digit enters at the MSB end, so after N steps sum is LSB-aligned.
    - carry ← c.
    - counter increments.
  - On step N−1 (the last step):
    - Next state is IDLE.
    - done ← 1 for one cycle.
    - carry_out ← c.
    - overflow ← (carry into bit WIDTH−1) XOR c. This is computed within the final digit's adder.
- Subtraction uses a + ~b + 1. carry_out=1 means no borrow.
- start, a, b and mode are ignored while busy=1.
- A start in the same cycle that done=1 is accepted. The FSM is already in IDLE, which gives back-to-back operation with no dead cycle.
- sum, carry_out and overflow hold their values until the next accepted start.
  - On an accepted start, carry_out and overflow clear to 0.
  - On an accepted start, sum clears to 0.
- contents_a and contents_b reflect a_reg and b_reg every cycle. They are all-zero after the final step.

## Timing
- Reset state, applied asynchronously while reset_n=0:
  - State is IDLE.
  - busy=0, done=0, carry_out=0, overflow=0.
  - sum, contents_a and contents_b are all zero.
  - Internal carry and counter are 0.
- Reset deassertion: start is sampled from the first rising edge after reset_n goes high.
- Start accepted at edge k:
  - busy=1 from edge k to edge k+N.
  - Digit steps occur at edges k+1 … k+N.
  - After edge k+N: busy=0, done=1, and results are valid. done drops after edge k+N+1 unless a new operation completes then.
- Total latency is N+1 edges from start to done. For WIDTH=16, DIGIT=1 this is 17 edges.
- Reset mid-operation: everything clears immediately and no done is produced. After release the block is idle.
- done and busy are never high together.

## Test plan
- Add with overflow (W=16, D=1): a=16'h83A9, b=16'h83A9, mode=0 -> done 17 edges after start, sum=16'h0752, carry_out=1, overflow=1. busy is high for exactly 16 cycles, and contents_a/contents_b shift right one bit per cycle.
- Subtract with borrow: a=16'h0005, b=16'h0007, mode=1 -> sum=16'hFFFE, carry_out=0, overflow=0. A second operation a=16'h8000, b=16'h0001, mode=1 -> sum=16'h7FFF, carry_out=1, overflow=1.
- Digit width (W=16, D=4): a=16'hFFFF, b=16'h0001, mode=0 -> done 5 edges after start, sum=16'h0000, carry_out=1, overflow=0. Repeat with W=32, D=8: a=32'h7FFFFFFF, b=1 -> sum=32'h80000000, carry_out=0, overflow=1.
- Handshake: pulse start with different operands during busy -> ignored, and the original result is unchanged. Assert start in the done cycle with a=1, b=2 -> accepted with no idle cycle, next sum=3.
- Reset mid-operation: drop reset_n at step 7 -> all outputs 0 immediately and no done pulse. After release, a=16'h00FF + b=16'h0001 -> sum=16'h0100.
- Post-reset defaults: check busy=0, done=0, sum=0, carry_out=0, overflow=0 and contents_a/contents_b=0 while reset_n=0 with clk running.
